// File: rtl/roi_color_sampler.sv
// ROI colour sampler: per-channel sums over a programmable rectangle, averaged by
// three parallel restoring dividers, plus a frame-latched binary pixel count.
module roi_color_sampler #(
  parameter int CH_W             = 8,
  parameter int CNT_W            = 12,
  parameter int ACC_W            = 32,
  parameter int BIN_W            = 21,
  parameter int FRAME_START_LINE = 1,
  parameter int DIV_LINE         = 479
) (
  input  logic                PClk,
  input  logic                Rst,
  input  logic [CNT_W-1:0]    VtcHCnt,
  input  logic [CNT_W-1:0]    VtcVCnt,
  input  logic [3*CH_W-1:0]   Pix,
  input  logic                Binary_PostProcess,
  input  logic [CNT_W-1:0]    roi_x0,
  input  logic [CNT_W-1:0]    roi_y0,
  input  logic [CNT_W-1:0]    roi_w,
  input  logic [CNT_W-1:0]    roi_h,
  input  logic                btn_ColorExtract,
  input  logic                sw_ColorClear,
  input  logic                sw_AutoTrack,
  output logic [3*CH_W-1:0]   Color_avg,
  output logic                avg_valid,
  output logic                roi_empty,
  output logic [3*CH_W-1:0]   Color_detect,
  output logic [BIN_W-1:0]    Binary_Sum
);

  localparam int DC_W = $clog2(ACC_W + 1);

  typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;
  state_t state_reg, state_next;

  logic frame_start, div_trig, in_roi;
  logic load, div_step, done_now, div_zero;
  logic [CNT_W-1:0]  x0_reg, y0_reg, w_reg, h_reg;
  logic [CNT_W:0]    h_ext, v_ext, x_end, y_end;
  logic [ACC_W-1:0]  count_reg, divisor_reg;
  logic [DC_W-1:0]   div_cnt_reg;
  logic [3*CH_W-1:0] avg_q, avg_reg, detect_reg;
  logic              valid_reg, empty_reg;
  logic [BIN_W-1:0]  bin_cnt_reg, bin_sum_reg;

  assign frame_start = (VtcVCnt == CNT_W'(FRAME_START_LINE)) && (VtcHCnt == '0);
  assign div_trig    = (VtcVCnt == CNT_W'(DIV_LINE)) && (VtcHCnt == '0);

  // One extra bit on the bounds so x0+w past the counter range cannot wrap.
  assign h_ext  = {1'b0, VtcHCnt};
  assign v_ext  = {1'b0, VtcVCnt};
  assign x_end  = {1'b0, x0_reg} + {1'b0, w_reg};
  assign y_end  = {1'b0, y0_reg} + {1'b0, h_reg};
  assign in_roi = (h_ext >= {1'b0, x0_reg}) && (h_ext < x_end) &&
                  (v_ext >= {1'b0, y0_reg}) && (v_ext < y_end);

  always_ff @(posedge PClk) begin
    if (Rst) begin
      x0_reg <= '0;
      y0_reg <= '0;
      w_reg  <= '0;
      h_reg  <= '0;
    end else if (frame_start) begin
      x0_reg <= roi_x0;
      y0_reg <= roi_y0;
      w_reg  <= roi_w;
      h_reg  <= roi_h;
    end
  end

  always_ff @(posedge PClk) begin
    if (Rst || frame_start)
      count_reg <= '0;
    else if (in_roi && (count_reg != '1))
      count_reg <= count_reg + 1'b1;
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      divisor_reg <= '0;
      div_cnt_reg <= '0;
    end else if (load) begin
      divisor_reg <= count_reg;
      div_cnt_reg <= '0;
    end else if (div_step) begin
      div_cnt_reg <= div_cnt_reg + 1'b1;
    end
  end

  assign div_zero = (divisor_reg == '0);

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic [CH_W-1:0]  ch;
    logic [ACC_W-1:0] sum_reg, quo_reg, rem_reg;
    logic [ACC_W:0]   sum_add, rem_shift, rem_sub;

    assign ch        = Pix[gi*CH_W +: CH_W];
    assign sum_add   = {1'b0, sum_reg} + {{(ACC_W+1-CH_W){1'b0}}, ch};
    assign rem_shift = {rem_reg, quo_reg[ACC_W-1]};
    assign rem_sub   = rem_shift - {1'b0, divisor_reg};
    assign avg_q[gi*CH_W +: CH_W] = quo_reg[CH_W-1:0];

    always_ff @(posedge PClk) begin
      if (Rst || frame_start)
        sum_reg <= '0;
      else if (in_roi)
        sum_reg <= sum_add[ACC_W] ? '1 : sum_add[ACC_W-1:0];
    end

    // Quotient shifts in through the dividend register; a negative trial leaves the remainder.
    always_ff @(posedge PClk) begin
      if (Rst) begin
        rem_reg <= '0;
        quo_reg <= '0;
      end else if (load) begin
        rem_reg <= '0;
        quo_reg <= sum_reg;
      end else if (div_step) begin
        rem_reg <= rem_sub[ACC_W] ? rem_shift[ACC_W-1:0] : rem_sub[ACC_W-1:0];
        quo_reg <= {quo_reg[ACC_W-2:0], ~rem_sub[ACC_W]};
      end
    end
  end

  always_ff @(posedge PClk) begin
    if (Rst) state_reg <= ACCUM;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    div_step   = 1'b0;
    done_now   = 1'b0;
    case (state_reg)
      ACCUM: begin
        if (div_trig) begin
          load       = 1'b1;
          state_next = (count_reg == '0) ? DONE : DIVIDE;
        end
      end
      DIVIDE: begin
        if (frame_start) begin
          state_next = ACCUM;
        end else begin
          div_step = 1'b1;
          if (div_cnt_reg == DC_W'(ACC_W - 1)) state_next = DONE;
        end
      end
      DONE: begin
        done_now   = 1'b1;
        state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      avg_reg   <= '0;
      valid_reg <= 1'b0;
      empty_reg <= 1'b1;
    end else begin
      valid_reg <= done_now && !div_zero;
      if (done_now) begin
        empty_reg <= div_zero;
        if (!div_zero) avg_reg <= avg_q;
      end
    end
  end

  always_ff @(posedge PClk) begin
    if (Rst || sw_ColorClear)
      detect_reg <= '1;
    else if (btn_ColorExtract)
      detect_reg <= avg_reg;
    else if (sw_AutoTrack && valid_reg)
      detect_reg <= avg_reg;
  end

  always_ff @(posedge PClk) begin
    if (Rst) begin
      bin_cnt_reg <= '0;
      bin_sum_reg <= '0;
    end else if (frame_start) begin
      bin_cnt_reg <= '0;
      bin_sum_reg <= bin_cnt_reg;
    end else if (Binary_PostProcess && (bin_cnt_reg != '1)) begin
      bin_cnt_reg <= bin_cnt_reg + 1'b1;
    end
  end

  assign Color_avg    = avg_reg;
  assign avg_valid    = valid_reg;
  assign roi_empty    = empty_reg;
  assign Color_detect = detect_reg;
  assign Binary_Sum   = bin_sum_reg;

endmodule
